// File: rtl/abc_reg_pkg.sv
// Shared constants and types for the ABC register pair front-door responder.
package abc_reg_pkg;

  // Word addresses on the 32-bit bus
  localparam logic [1:0] ADDR_R1_LO = 2'd0;
  localparam logic [1:0] ADDR_R1_HI = 2'd1;
  localparam logic [1:0] ADDR_R2_LO = 2'd2;
  localparam logic [1:0] ADDR_R2_HI = 2'd3;

  // Reset values shared with the backdoor-accessed registers
  localparam logic [63:0] R1_RESET_DEF = 64'h0000_0000_1234_5678;
  localparam logic [63:0] R2_RESET_DEF = 64'h0000_0000_DEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_CLR  = 2'd2,
    ST_LOAD = 2'd3
  } state_e;

endpackage

// File: rtl/abc_reg64_slot.sv
// One 64-bit register with the read shadow and write stage that make
// low-then-high 32-bit access pairs atomic.
module abc_reg64_slot
  import abc_reg_pkg::*;
#(
  parameter logic [63:0] R_RESET = R1_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,    // hold register at zero
  input  logic        load,   // reload reset value, wipe shadow/stage
  input  logic        wr_en,  // accepted write to this slot
  input  logic        rd_en,  // accepted read from this slot
  input  logic        hi,     // 1 = upper word
  input  logic [31:0] wdata,
  output logic [63:0] q,
  output logic [31:0] rdata
);

  logic [31:0] shadow;
  logic [31:0] stage;

  // Upper-word reads come from the shadow captured by the last lower-word read
  assign rdata = hi ? shadow : q[31:0];

  // Register, shadow and stage update; load beats clear beats bus access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= R_RESET;
      shadow <= '0;
      stage  <= '0;
    end else if (load) begin
      q      <= R_RESET;
      shadow <= '0;
      stage  <= '0;
    end else if (clr) begin
      q      <= '0;
    end else begin
      if (wr_en) begin
        if (!hi) stage <= wdata;
        else     q     <= {wdata, stage};
      end
      if (rd_en && !hi) shadow <= q[63:32];
    end
  end

endmodule

// File: rtl/abc_reg_responder.sv
// Front-door request/response responder for the ABC r1/r2 register pair,
// including the clear-then-load soft-reset sequence.
module abc_reg_responder
  import abc_reg_pkg::*;
#(
  parameter logic [63:0] R1_RESET   = R1_RESET_DEF,
  parameter logic [63:0] R2_RESET   = R2_RESET_DEF,
  parameter int          CLR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [63:0] r1_q,
  output logic [63:0] r2_q,
  output logic        busy
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_e        state;
  logic [CW-1:0] cnt;
  logic          pending;
  logic          soft_rst_d;
  logic          sr_edge;
  logic          accept;
  logic          sel_r2;
  logic          hi;
  logic          enter_clr;
  logic          clr;
  logic          load;
  logic          cnt_last;
  logic [31:0]   rdata1;
  logic [31:0]   rdata2;

  assign sr_edge   = soft_rst && !soft_rst_d;
  assign req_ready = (state == ST_IDLE) && !sr_edge && !pending;
  assign accept    = req_valid && req_ready;
  assign sel_r2    = (req_addr == ADDR_R2_LO) || (req_addr == ADDR_R2_HI);
  assign hi        = (req_addr == ADDR_R1_HI) || (req_addr == ADDR_R2_HI);

  assign enter_clr = (state == ST_IDLE) && (sr_edge || pending);
  assign cnt_last  = (cnt == CW'(CLR_CYCLES - 1));
  assign clr       = enter_clr || (state == ST_CLR);
  // Reset values land on the CLR->LOAD edge so they are visible during LOAD
  assign load      = (state == ST_CLR) && cnt_last;

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state == ST_CLR) || (state == ST_LOAD);
  assign rsp_err   = 1'b0;

  abc_reg64_slot #(.R_RESET(R1_RESET)) u_r1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (load),
    .wr_en (accept && req_write && !sel_r2),
    .rd_en (accept && !req_write && !sel_r2),
    .hi    (hi),
    .wdata (req_wdata),
    .q     (r1_q),
    .rdata (rdata1)
  );

  abc_reg64_slot #(.R_RESET(R2_RESET)) u_r2 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (load),
    .wr_en (accept && req_write && sel_r2),
    .rd_en (accept && !req_write && sel_r2),
    .hi    (hi),
    .wdata (req_wdata),
    .q     (r2_q),
    .rdata (rdata2)
  );

  // Control FSM: one access at a time, soft reset deferred past an open response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      soft_rst_d <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      soft_rst_d <= soft_rst;
      case (state)
        ST_IDLE: begin
          if (sr_edge || pending) begin
            state   <= ST_CLR;
            pending <= 1'b0;
            cnt     <= '0;
          end else if (accept) begin
            state     <= ST_RESP;
            rsp_rdata <= req_write ? 32'h0 : (sel_r2 ? rdata2 : rdata1);
          end
        end
        ST_RESP: begin
          if (sr_edge)   pending <= 1'b1;
          if (rsp_ready) state   <= ST_IDLE;
        end
        ST_CLR: begin
          if (cnt_last) state <= ST_LOAD;
          else          cnt   <= cnt + CW'(1);
        end
        ST_LOAD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abc_reg_responder.sv
// Directed plus randomized bench for abc_reg_responder against a word-level model.
module tb_abc_reg_responder;

  localparam logic [63:0] R1D = 64'h0000_0000_1234_5678;
  localparam logic [63:0] R2D = 64'h0000_0000_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        soft_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] r1_q;
  logic [63:0] r2_q;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Model: registers, read shadows and write stages, indexed 0 = r1, 1 = r2
  logic [63:0] m_r  [2];
  logic [31:0] m_sh [2];
  logic [31:0] m_st [2];

  abc_reg_responder dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst  (soft_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .r1_q      (r1_q),
    .r2_q      (r2_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_r[0] = R1D; m_r[1] = R2D;
    for (int i = 0; i < 2; i++) begin m_sh[i] = '0; m_st[i] = '0; end
  endfunction

  function automatic logic [31:0] m_op(input bit wr, input logic [1:0] a, input logic [31:0] d);
    int s;
    s = a[1] ? 1 : 0;
    if (wr) begin
      if (!a[0]) m_st[s] = d;
      else       m_r[s]  = {d, m_st[s]};
      return 32'h0;
    end
    if (!a[0]) begin
      m_sh[s] = m_r[s][63:32];
      return m_r[s][31:0];
    end
    return m_sh[s];
  endfunction

  // One bus transaction with rsp_ready high; starts and ends just after a posedge
  task automatic bus(input bit wr, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", {63'h0, req_ready}, 64'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rsp_valid_lat1", {63'h0, rsp_valid}, 64'h1);
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  // Bus op compared against the model, including the register outputs
  task automatic op_chk(input string tag, input bit wr, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd, exp;
    logic er;
    exp = m_op(wr, a, d);
    bus(wr, a, d, rd, er);
    chk({tag, "_rdata"}, {32'h0, rd}, {32'h0, exp});
    chk({tag, "_err"}, {63'h0, er}, 64'h0);
    chk({tag, "_r1"}, r1_q, m_r[0]);
    chk({tag, "_r2"}, r2_q, m_r[1]);
  endtask

  // Soft-reset pulse in IDLE, then wait for the sequence to finish
  task automatic sr_pulse();
    int n;
    soft_rst = 1'b1;
    @(posedge clk); #1;
    soft_rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("sr_done", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    m_reset();
  endtask

  initial begin
    logic [31:0] rd0, rdata_hold;
    logic        er0;
    int n;
    rst = 1'b1; soft_rst = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    @(negedge clk);
    chk("rst_r1", r1_q, R1D);
    chk("rst_r2", r2_q, R2D);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
    @(posedge clk); #1;

    // Atomic write pair to r1
    op_chk("wr_r1_lo", 1'b1, 2'd0, 32'hAAAA_5555);
    chk("wr_r1_lo_unchanged", r1_q, 64'h0000_0000_1234_5678);
    op_chk("wr_r1_hi", 1'b1, 2'd1, 32'h0123_4567);
    chk("wr_r1_commit", r1_q, 64'h0123_4567_AAAA_5555);

    // Shadowed read of r2: the high word changes between the two reads
    op_chk("set_r2_lo", 1'b1, 2'd2, 32'h3333_4444);
    op_chk("set_r2_hi", 1'b1, 2'd3, 32'h1111_2222);
    chk("r2_set", r2_q, 64'h1111_2222_3333_4444);
    op_chk("rd_r2_lo", 1'b0, 2'd2, 32'h0);
    op_chk("chg_r2_hi", 1'b1, 2'd3, 32'h9999_9999);
    bus(1'b0, 2'd3, 32'h0, rd0, er0);
    chk("rd_r2_hi_shadow", {32'h0, rd0}, 64'h1111_2222);
    void'(m_op(1'b0, 2'd3, 32'h0));

    // Soft reset from all-ones: 2 cycles of zero, then reset values during LOAD
    op_chk("ff_lo", 1'b1, 2'd0, 32'hFFFF_FFFF);
    op_chk("ff_hi", 1'b1, 2'd1, 32'hFFFF_FFFF);
    soft_rst = 1'b1;
    @(negedge clk);
    chk("sr_edge_ready", {63'h0, req_ready}, 64'h0);
    @(posedge clk); #1;
    soft_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sr_busy", {63'h0, busy}, (i < 3) ? 64'h1 : 64'h0);
      chk("sr_r1", r1_q, (i < 2) ? 64'h0 : R1D);
      chk("sr_ready", {63'h0, req_ready}, (i < 3) ? 64'h0 : 64'h1);
      @(posedge clk); #1;
    end
    m_reset();
    op_chk("post_sr_rd_hi", 1'b0, 2'd1, 32'h0);

    // Stalled response with a soft reset arriving mid-stall
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd0;
    @(negedge clk);
    chk("stall_accept", {63'h0, req_ready}, 64'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rdata_hold = m_op(1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {63'h0, rsp_valid}, 64'h1);
      chk("stall_rdata", {32'h0, rsp_rdata}, {32'h0, rdata_hold});
      @(posedge clk); #1;
      if (i == 1) soft_rst = 1'b1;
      if (i == 2) soft_rst = 1'b0;
      if (i == 4) rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("stall_busy_before_hs", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hs_rsp_dropped", {63'h0, rsp_valid}, 64'h0);
    chk("hs_busy_idle", {63'h0, busy}, 64'h0);
    chk("hs_pending_blocks", {63'h0, req_ready}, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pending_clr_busy", {63'h0, busy}, 64'h1);
    chk("pending_clr_r1", r1_q, 64'h0);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("pending_done_r1", r1_q, R1D);
    @(posedge clk); #1;
    m_reset();

    // Randomized traffic with occasional soft resets
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) sr_pulse();
      else op_chk("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
    end

    // Hard reset in the middle of CLR
    op_chk("pre_rst_wr", 1'b1, 2'd2, 32'h5A5A_5A5A);
    soft_rst = 1'b1;
    @(posedge clk); #1;
    soft_rst = 1'b0;
    @(negedge clk);
    chk("mid_clr_busy", {63'h0, busy}, 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("arst_r1", r1_q, R1D);
    chk("arst_r2", r2_q, R2D);
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    m_reset();
    op_chk("post_arst_rd_hi", 1'b0, 2'd3, 32'h0);
    op_chk("post_arst_rd_lo", 1'b0, 2'd2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/abc_reg_responder.md
Name: abc_reg_responder

Overview:
- Front-door bus responder for the ABC register pair: two 64-bit registers, r1 and r2, accessed over a 32-bit request/response bus.
- Provides the bus path that complements the existing backdoor-accessed ABC registers, with the same reset values and the same clear-then-load soft-reset sequence.
- Sits between the bus interconnect and the ABC register consumers; r1_q/r2_q feed the downstream logic directly.

Parameters:
- R1_RESET, 64'h0000_0000_1234_5678, load value for r1 on reset.
- R2_RESET, 64'h0000_0000_DEAD_BEEF, load value for r2 on reset.
- CLR_CYCLES, 2, number of cycles registers are held at 0 during a soft reset (minimum 1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- soft_rst  in  1  a rising edge starts the soft-reset sequence.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  2  word address: 0 = r1[31:0], 1 = r1[63:32], 2 = r2[31:0], 3 = r2[63:32].
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  error flag; always 0 in this revision, since all 4 addresses are decoded.
- r1_q  out  64  current r1.
- r2_q  out  64  current r2.
- busy  out  1  high during the soft-reset sequence.

Behaviour:
- Reset (rst high), applied asynchronously:
  - r1_q = R1_RESET, r2_q = R2_RESET.
  - Shadow and staging registers = 0.
  - FSM = IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - soft_rst edge-detect register = 0; soft-reset pending flag = 0.
- Soft-reset edge detection: sr_edge = soft_rst && !soft_rst_d, where soft_rst_d is soft_rst registered.
- FSM states: IDLE, RESP, CLR, LOAD.
- req_ready = (state == IDLE) && !sr_edge && !pending. The ready signal is combinational; valid must not depend on ready.
- IDLE:
  - If sr_edge or pending, go to CLR, clear pending, and zero r1/r2.
  - Otherwise, on accept, perform the access, drive rsp_valid = 1 the next cycle (latency 1), and go to RESP.
- Read access:
  - addr 0: return r1[31:0] and capture r1[63:32] into shadow1.
  - addr 1: return shadow1.
  - addr 2 and addr 3: same scheme using shadow2.
  - This makes a low-then-high read pair atomic. A high read without a preceding low read returns the last shadow value (0 after reset).
- Write access:
  - addr 0/2: store wdata into stage1/stage2. The register is unchanged.
  - addr 1/3: commit {wdata, stage} to r1/r2 in a single cycle. This makes a low-then-high write pair atomic.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; on handshake, drop rsp_valid and return to IDLE.
  - An sr_edge seen while in RESP sets pending. The response completes first, then the soft reset runs.
- CLR: busy = 1; r1 = r2 = 0 for CLR_CYCLES cycles (counter), then go to LOAD.
- LOAD: r1 = R1_RESET, r2 = R2_RESET; shadows and stages cleared to 0; busy = 1 for this cycle; next state IDLE.
- An sr_edge during CLR/LOAD is ignored; pending is not set.
- rst asserted at any point aborts everything and returns to the reset values above. Any in-flight response is dropped.
- Simultaneous sr_edge and req_valid in IDLE: the soft reset wins and the request is not accepted; the requester keeps req_valid.

Decomposition:
- Shared package abc_reg_pkg holds:
  - Address constants ADDR_R1_LO/HI, ADDR_R2_LO/HI.
  - State enum typedef.
  - Default reset-value constants R1_RESET_DEF and R2_RESET_DEF.
- The per-register datapath is a natural sub-module, abc_reg64_slot, instantiated twice. It holds the register, shadow, stage, read mux, commit logic and clear/load inputs.

Test Plan:
- Release rst, no traffic -> r1_q = 64'h12345678, r2_q = 64'hDEADBEEF, busy = 0, rsp_valid = 0.
- Write addr0 = 32'hAAAA_5555, then addr1 = 32'h0123_4567 -> r1_q stays 64'h12345678 after the first write; becomes 64'h01234567_AAAA5555 exactly one cycle after the second is accepted. Both responses have rdata = 0, err = 0.
- Set r2 = 64'h1111_2222_3333_4444; read addr2; backdoor-change r2[63:32] to 32'h9999_9999; read addr3 -> responses 32'h3333_4444 then 32'h1111_2222 (shadow).
- Pulse soft_rst with r1 = 64'hFFFF_FFFF_FFFF_FFFF -> busy high 3 cycles; r1_q = 0 for 2 cycles, then 64'h12345678; req_ready = 0 throughout.
- Accept a read, hold rsp_ready = 0 for 5 cycles, pulse soft_rst during that -> rsp_rdata stable all 5 cycles; CLR starts the cycle after the handshake.
- Assert rst mid-CLR -> outputs immediately take the reset values; rsp_valid = 0, busy = 0.
